// File: rtl/sp_if_ddr_access_ctrl.sv
// DDR access order controller: resolves the frame bank and splits an order into
// Avalon-MM bursts that never cross a P_BURST_MAX boundary. Optional stall watchdog
// is built when SP_IF_DDR_TIMEOUT_EN is defined.
//
// state   | meaning
// IDLE    | waiting for a rising edge of i_ddr_start
// CALC    | resolve bank, physical address and first burst length
// RD_CMD  | read command presented until accepted
// RD_WAIT | collecting beats of the single outstanding read burst
// WR_BEAT | write beats presented until the last beat of the order
// DONE    | one-cycle order-complete pulse
module sp_if_ddr_access_ctrl #(
  parameter int          P_BURST_MAX = 64,
  parameter logic [26:0] P_BANK_OFS  = 27'h0100000,
  parameter int          P_TMO_CYC   = 65535
) (
  input  logic         i_clk156m,
  input  logic         i_arst_n,
  input  logic [3:0]   i_frame_time,
  input  logic [3:0]   i_frame_max,
  input  logic         i_ddr_start,
  input  logic         i_ddr_wxr,
  input  logic [3:0]   i_ddr_area,
  input  logic [26:0]  i_ddr_addr,
  input  logic [31:0]  i_ddr_size,
  input  logic [127:0] i_wr_data,
  output logic         o_wr_data_req,
  output logic [26:0]  o_avm_address,
  output logic [7:0]   o_avm_burstcount,
  output logic         o_avm_read,
  output logic         o_avm_write,
  output logic [127:0] o_avm_writedata,
  input  logic         i_avm_waitrequest,
  input  logic         i_avm_readdatavalid,
  output logic         o_rd_valid,
  output logic         o_busy,
  output logic         o_ddr_endp,
  output logic         o_ddr_err
);
  localparam int BW = $clog2(P_BURST_MAX);

  typedef enum logic [2:0] {IDLE, CALC, RD_CMD, RD_WAIT, WR_BEAT, DONE} state_t;
  state_t state, state_nx;

  logic         start_d, start_edge;
  logic         wxr_r;
  logic [3:0]   area_r;
  logic [26:0]  addr_r;
  logic [27:0]  rem_r, rem_nx;
  logic [26:0]  cur_addr, cur_addr_nx;
  logic [7:0]   burst_r, burst_nx, beat_cnt, beat_cnt_nx;
  logic         beat_ok;
  logic         rd_valid_r;
  logic [1:0]   back;
  logic [4:0]   bank_diff;
  logic [3:0]   bank;
  logic [26:0]  phys_addr;
  logic         unused_size_lsb;

  assign unused_size_lsb = ^i_ddr_size[3:0];

  function automatic logic [7:0] burst_len(input logic [26:0] addr, input logic [27:0] rem);
    logic [7:0] room;
    room = 8'(P_BURST_MAX) - 8'(addr[BW-1:0]);
    if (rem < {20'd0, room}) return rem[7:0];
    return room;
  endfunction

  assign start_edge = (state == IDLE) && i_ddr_start && !start_d;

  // frame_max+1 wraps a negative difference back into the bank ring
  always_comb begin
    back      = (area_r != 4'd0 && area_r < 4'd4) ? area_r[1:0] : 2'd0;
    bank_diff = {1'b0, i_frame_time} - {3'b000, back};
    bank      = bank_diff[4] ? (bank_diff[3:0] + i_frame_max + 4'd1) : bank_diff[3:0];
    phys_addr = addr_r + ({23'd0, bank} * P_BANK_OFS);
  end

`ifdef SP_IF_DDR_TIMEOUT_EN
  logic [31:0] tmo_cnt;
  logic        err_r, stall, tmo_hit;

  assign stall   = ((state == RD_CMD || state == WR_BEAT) && i_avm_waitrequest) ||
                   (state == RD_WAIT && !i_avm_readdatavalid);
  assign tmo_hit = stall && (tmo_cnt == 32'd0);

  always_ff @(posedge i_clk156m or negedge i_arst_n) begin
    if (!i_arst_n) begin
      tmo_cnt <= 32'(P_TMO_CYC - 1);
      err_r   <= 1'b0;
    end else begin
      if (stall && tmo_cnt != 32'd0) tmo_cnt <= tmo_cnt - 32'd1;
      else                           tmo_cnt <= 32'(P_TMO_CYC - 1);
      err_r <= tmo_hit;
    end
  end

  assign o_ddr_err = err_r;
`else
  logic [31:0] unused_tmo;
  assign unused_tmo = 32'(P_TMO_CYC);
  assign o_ddr_err  = 1'b0;
`endif

  always_comb begin
    state_nx    = state;
    rem_nx      = rem_r;
    cur_addr_nx = cur_addr;
    burst_nx    = burst_r;
    beat_cnt_nx = beat_cnt;
    beat_ok     = 1'b0;
    case (state)
      IDLE: if (start_edge) begin
        state_nx = CALC;
        rem_nx   = i_ddr_size[31:4];
      end
      CALC: begin
        cur_addr_nx = phys_addr;
        burst_nx    = burst_len(phys_addr, rem_r);
        beat_cnt_nx = burst_nx;
        if (rem_r == 28'd0) state_nx = DONE;
        else if (wxr_r)     state_nx = WR_BEAT;
        else                state_nx = RD_CMD;
      end
      RD_CMD:  if (!i_avm_waitrequest) state_nx = RD_WAIT;
      RD_WAIT: beat_ok = i_avm_readdatavalid;
      WR_BEAT: beat_ok = !i_avm_waitrequest;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    if (beat_ok) begin
      beat_cnt_nx = beat_cnt - 8'd1;
      if (beat_cnt == 8'd1) begin
        if (rem_r == {20'd0, burst_r}) begin
          state_nx = DONE;
        end else begin
          rem_nx      = rem_r - {20'd0, burst_r};
          cur_addr_nx = cur_addr + {19'd0, burst_r};
          burst_nx    = burst_len(cur_addr_nx, rem_nx);
          beat_cnt_nx = burst_nx;
          if (!wxr_r) state_nx = RD_CMD;
        end
      end
    end
`ifdef SP_IF_DDR_TIMEOUT_EN
    if (tmo_hit) state_nx = DONE;
`endif
  end

  always_ff @(posedge i_clk156m or negedge i_arst_n) begin
    if (!i_arst_n) begin
      state      <= IDLE;
      start_d    <= 1'b0;
      wxr_r      <= 1'b0;
      area_r     <= 4'd0;
      addr_r     <= 27'd0;
      rem_r      <= 28'd0;
      cur_addr   <= 27'd0;
      burst_r    <= 8'd0;
      beat_cnt   <= 8'd0;
      rd_valid_r <= 1'b0;
    end else begin
      state      <= state_nx;
      start_d    <= i_ddr_start;
      rem_r      <= rem_nx;
      cur_addr   <= cur_addr_nx;
      burst_r    <= burst_nx;
      beat_cnt   <= beat_cnt_nx;
      rd_valid_r <= i_avm_readdatavalid;
      if (start_edge) begin
        wxr_r  <= i_ddr_wxr;
        area_r <= i_ddr_area;
        addr_r <= i_ddr_addr;
      end
    end
  end

  assign o_avm_read       = (state == RD_CMD);
  assign o_avm_write      = (state == WR_BEAT);
  assign o_wr_data_req    = (state == WR_BEAT) && !i_avm_waitrequest;
  assign o_avm_writedata  = i_wr_data;
  assign o_avm_address    = cur_addr;
  assign o_avm_burstcount = burst_r;
  assign o_rd_valid       = rd_valid_r;
  assign o_busy           = (state != IDLE);
  assign o_ddr_endp       = (state == DONE);

endmodule

// File: tb/tb_sp_if_ddr_access_ctrl.sv
// Directed bench for sp_if_ddr_access_ctrl: table of orders with hand-computed
// addresses/bursts, plus sequences for back-to-back, reset mid-burst and stall.
module tb_sp_if_ddr_access_ctrl;
  localparam int BM = 64;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [3:0]   i_frame_time = '0, i_frame_max = '0, i_ddr_area = '0;
  logic         i_ddr_start = 1'b0, i_ddr_wxr = 1'b0;
  logic [26:0]  i_ddr_addr = '0;
  logic [31:0]  i_ddr_size = '0;
  logic [127:0] i_wr_data = '0;
  logic         i_avm_waitrequest = 1'b0, i_avm_readdatavalid = 1'b0;
  logic         o_wr_data_req, o_avm_read, o_avm_write, o_rd_valid, o_busy, o_ddr_endp, o_ddr_err;
  logic [26:0]  o_avm_address;
  logic [7:0]   o_avm_burstcount;
  logic [127:0] o_avm_writedata;

  always #5 clk = ~clk;

  sp_if_ddr_access_ctrl #(.P_BURST_MAX(BM), .P_TMO_CYC(100)) dut (
    .i_clk156m(clk), .i_arst_n(rst_n), .i_frame_time(i_frame_time), .i_frame_max(i_frame_max),
    .i_ddr_start(i_ddr_start), .i_ddr_wxr(i_ddr_wxr), .i_ddr_area(i_ddr_area),
    .i_ddr_addr(i_ddr_addr), .i_ddr_size(i_ddr_size), .i_wr_data(i_wr_data),
    .o_wr_data_req(o_wr_data_req), .o_avm_address(o_avm_address),
    .o_avm_burstcount(o_avm_burstcount), .o_avm_read(o_avm_read), .o_avm_write(o_avm_write),
    .o_avm_writedata(o_avm_writedata), .i_avm_waitrequest(i_avm_waitrequest),
    .i_avm_readdatavalid(i_avm_readdatavalid), .o_rd_valid(o_rd_valid), .o_busy(o_busy),
    .o_ddr_endp(o_ddr_endp), .o_ddr_err(o_ddr_err)
  );

  typedef struct {
    logic        wxr;
    logic [3:0]  area, ft, fm;
    logic [26:0] addr;
    logic [31:0] size;
    bit          rand_wait, glitch;
    logic [26:0] exp_addr;
    logic [7:0]  exp_burst;
    int          exp_beats, exp_bursts;
  } vec_t;

  vec_t vecs[9];
  int n_checks = 0, n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [41:0] outs();
    return {o_avm_read, o_avm_write, o_wr_data_req, o_avm_address, o_avm_burstcount,
            o_rd_valid, o_busy, o_ddr_endp, o_ddr_err};
  endfunction

  task automatic run_order(input int id, input vec_t v);
    int cyc = 0, beats = 0, bursts = 0, endp_cnt = 0, endp_cyc = 0, last_cyc = 0;
    int pend = 0, in_burst = 0, err_seen = 0, proto_err = 0, rule_err = 0;
    int first_cmd_cyc = 0, rem, room, exp_bc, busy_after = 0;
    logic [26:0] nxt_addr, cur_a = '0, first_a = '0;
    logic [7:0]  cur_bc = '0, first_bc = '0;
    logic        prev_rdv = 1'b0;
    bit          done = 0;
    rem = int'(v.size[31:4]);
    nxt_addr = v.exp_addr;
    @(negedge clk);
    i_ddr_wxr = v.wxr; i_ddr_area = v.area; i_frame_time = v.ft; i_frame_max = v.fm;
    i_ddr_addr = v.addr; i_ddr_size = v.size; i_ddr_start = 1'b1;
    i_avm_waitrequest = 1'b0; i_avm_readdatavalid = 1'b0;
    while (!done && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      if (v.glitch) begin
        if (cyc == 5)  i_ddr_start = 1'b0;
        if (cyc == 9)  i_ddr_start = 1'b1;
        if (cyc == 14) i_ddr_start = 1'b0;
      end
      i_wr_data = {$urandom(), $urandom(), $urandom(), $urandom()};
      i_avm_waitrequest   = v.rand_wait ? ($urandom_range(0, 2) == 0) : 1'b0;
      i_avm_readdatavalid = (pend > 0) && (!v.rand_wait || $urandom_range(0, 1) == 1);
      #1;
      if (o_rd_valid !== prev_rdv) proto_err++;
      prev_rdv = i_avm_readdatavalid;
      if (o_wr_data_req !== (o_avm_write && !i_avm_waitrequest)) proto_err++;
      if (o_avm_writedata !== i_wr_data) proto_err++;
      if (cyc == 1 && (o_busy !== 1'b1 || o_avm_read || o_avm_write)) proto_err++;
      if (o_avm_read && pend > 0) proto_err++;
      if ((o_avm_read || o_avm_write) && first_cmd_cyc == 0) first_cmd_cyc = cyc;
      if (i_avm_readdatavalid) begin
        beats++; pend--; last_cyc = cyc;
      end
      if ((o_avm_read && !i_avm_waitrequest) || (o_avm_write && in_burst == 0)) begin
        room   = BM - int'(nxt_addr % BM);
        exp_bc = (rem < room) ? rem : room;
        if (bursts == 0) begin first_a = o_avm_address; first_bc = o_avm_burstcount; end
        if (o_avm_address !== nxt_addr || o_avm_burstcount !== 8'(exp_bc)) rule_err++;
        cur_a = o_avm_address; cur_bc = o_avm_burstcount;
        nxt_addr = nxt_addr + 27'(exp_bc);
        rem = rem - exp_bc;
        bursts++;
        if (o_avm_read) pend = pend + int'(o_avm_burstcount);
        else            in_burst = int'(o_avm_burstcount);
      end else if (o_avm_write && (o_avm_address !== cur_a || o_avm_burstcount !== cur_bc)) begin
        rule_err++;
      end
      if (o_wr_data_req) begin
        beats++; in_burst--; last_cyc = cyc;
      end
      if (endp_cnt > 0 && cyc == endp_cyc + 1 && o_busy) busy_after = 1;
      if (o_ddr_endp) begin
        endp_cnt++; endp_cyc = cyc;
        if (o_ddr_err) err_seen++;
      end
      if (endp_cnt > 0 && cyc >= endp_cyc + 3) done = 1;
    end
    check($sformatf("v%0d_completed", id), 64'(done), 64'd1);
    check($sformatf("v%0d_endp_count", id), 64'(endp_cnt), 64'd1);
    check($sformatf("v%0d_endp_cycle", id), 64'(endp_cyc),
          64'((v.exp_beats == 0) ? 2 : last_cyc + 1));
    check($sformatf("v%0d_first_cmd_cycle", id), 64'(first_cmd_cyc),
          64'((v.exp_beats == 0) ? 0 : 2));
    check($sformatf("v%0d_beats", id), 64'(beats), 64'(v.exp_beats));
    check($sformatf("v%0d_bursts", id), 64'(bursts), 64'(v.exp_bursts));
    check($sformatf("v%0d_burst_rule_errs", id), 64'(rule_err), 64'd0);
    check($sformatf("v%0d_protocol_errs", id), 64'(proto_err), 64'd0);
    check($sformatf("v%0d_err_flag", id), 64'(err_seen), 64'd0);
    check($sformatf("v%0d_idle_after_endp", id), 64'(busy_after), 64'd0);
    if (v.exp_beats > 0) begin
      check($sformatf("v%0d_first_addr", id), 64'(first_a), 64'(v.exp_addr));
      check($sformatf("v%0d_first_burst", id), 64'(first_bc), 64'(v.exp_burst));
    end
    @(negedge clk);
    i_ddr_start = 1'b0; i_avm_waitrequest = 1'b0; i_avm_readdatavalid = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int endp_seen, endp_c, err_c;
    logic busy_end;
    vecs[0] = '{1'b0, 4'd0, 4'd2, 4'd3, 27'h10,      32'h400,  1'b0, 1'b0, 27'h0200010, 8'd48, 64,  2};
    vecs[1] = '{1'b1, 4'd3, 4'd1, 4'd3, 27'h0,       32'h640,  1'b1, 1'b0, 27'h0200000, 8'd64, 100, 2};
    vecs[2] = '{1'b0, 4'd1, 4'd0, 4'd3, 27'h5,       32'h0,    1'b0, 1'b0, 27'h0,       8'd0,  0,   0};
    vecs[3] = '{1'b1, 4'd0, 4'd2, 4'd3, 27'h5,       32'hF,    1'b0, 1'b0, 27'h0,       8'd0,  0,   0};
    vecs[4] = '{1'b0, 4'd1, 4'd0, 4'd7, 27'h3F,      32'h30,   1'b1, 1'b0, 27'h070003F, 8'd1,  3,   2};
    vecs[5] = '{1'b1, 4'd2, 4'd3, 4'd3, 27'h20,      32'h10,   1'b0, 1'b0, 27'h0100020, 8'd1,  1,   1};
    vecs[6] = '{1'b0, 4'd5, 4'd4, 4'd7, 27'h100,     32'h2000, 1'b0, 1'b0, 27'h0400100, 8'd64, 512, 8};
    vecs[7] = '{1'b1, 4'd0, 4'd1, 4'd3, 27'h7FFFFC0, 32'h4F,   1'b1, 1'b0, 27'h00FFFC0, 8'd4,  4,   1};
    vecs[8] = '{1'b0, 4'd0, 4'd2, 4'd3, 27'h10,      32'h400,  1'b0, 1'b1, 27'h0200010, 8'd48, 64,  2};

    repeat (3) @(negedge clk);
    #1 check("reset_outputs", 64'(outs()), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // read beat in IDLE is only forwarded
    i_avm_readdatavalid = 1'b1;
    @(negedge clk);
    i_avm_readdatavalid = 1'b0;
    #1 check("idle_rdv_forwarded", 64'({o_rd_valid, o_busy}), 64'b10);

    for (int i = 0; i < 9; i++) run_order(i, vecs[i]);

    // back-to-back zero-size orders: second edge in the cycle after endp
    @(negedge clk);
    i_ddr_size = 32'h0; i_ddr_start = 1'b1;
    @(negedge clk); #1 check("b2b_calc_busy", 64'(o_busy), 64'd1);
    @(negedge clk); #1 check("b2b_first_endp", 64'(o_ddr_endp), 64'd1);
    i_ddr_start = 1'b0;
    @(negedge clk); #1 check("b2b_idle", 64'(o_busy), 64'd0);
    i_ddr_start = 1'b1;
    @(negedge clk); #1 check("b2b_second_busy", 64'(o_busy), 64'd1);
    @(negedge clk); #1 check("b2b_second_endp", 64'(o_ddr_endp), 64'd1);
    i_ddr_start = 1'b0;
    @(negedge clk);

    // reset mid write burst
    i_ddr_wxr = 1'b1; i_ddr_area = 4'd0; i_frame_time = 4'd1; i_frame_max = 4'd3;
    i_ddr_addr = 27'h0; i_ddr_size = 32'h400; i_avm_waitrequest = 1'b0; i_ddr_start = 1'b1;
    repeat (10) @(negedge clk);
    #1 check("rst_mid_write_active", 64'(o_avm_write), 64'd1);
    rst_n = 1'b0; i_ddr_start = 1'b0;
    #1 check("rst_mid_outputs", 64'(outs()), 64'd0);
    endp_seen = 0;
    repeat (3) begin
      @(negedge clk); #1;
      if (o_ddr_endp || o_busy) endp_seen++;
    end
    check("rst_mid_no_endp", 64'(endp_seen), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    run_order(20, vecs[5]);
    run_order(21, vecs[0]);

    // stall: waitrequest stuck high on a read
    i_ddr_wxr = 1'b0; i_ddr_area = 4'd0; i_frame_time = 4'd0; i_ddr_addr = 27'h0;
    i_ddr_size = 32'h10; i_avm_waitrequest = 1'b1; i_ddr_start = 1'b1;
    endp_c = 0; err_c = 0; endp_seen = 0;
    for (int c = 1; c <= 200; c++) begin
      @(negedge clk); #1;
      if (o_ddr_endp) begin endp_c = c; endp_seen++; if (o_ddr_err) err_c++; end
    end
    busy_end = o_busy;
`ifdef SP_IF_DDR_TIMEOUT_EN
    check("tmo_endp_cycle", 64'(endp_c), 64'd102);
    check("tmo_endp_count", 64'(endp_seen), 64'd1);
    check("tmo_err_with_endp", 64'(err_c), 64'd1);
    check("tmo_idle_after", 64'(busy_end), 64'd0);
`else
    check("stall_no_endp", 64'(endp_seen), 64'd0);
    check("stall_still_busy", 64'(busy_end), 64'd1);
`endif
    rst_n = 1'b0; i_ddr_start = 1'b0; i_avm_waitrequest = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_order(30, vecs[4]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/sp_if_ddr_access_ctrl.md
# sp_if_ddr_access_ctrl

Downstream of the signal-processing interface controller. It takes one DDR access order at a time: read/write, area, start address and byte size, held on `i_ddr_start`. It resolves the area into a physical frame bank and splits the transfer into aligned Avalon-MM bursts. It returns a single `o_ddr_endp` pulse when the order has finished.

## Interface
Parameters:
- `P_BURST_MAX`, 64: maximum beats per burst; power of 2, range 2..128.
- `P_BANK_OFS`, 27'h0100000: beat-address offset between consecutive frame banks.
- `P_TMO_CYC`, 65535: stall watchdog limit in cycles (used only with the macro).

Ports:
- `i_clk156m`  in  1  system clock, 156.25 MHz.
- `i_arst_n`  in  1  asynchronous, active-low reset.
- `i_frame_time`  in  4  current frame counter.
- `i_frame_max`  in  4  frame counter terminal value, 0-origin.
- `i_ddr_start`  in  1  access order valid; level signal, held until end.
- `i_ddr_wxr`  in  1  0 = read, 1 = write.
- `i_ddr_area`  in  4  1..3 = N frames back; 0 and 4..15 = current frame.
- `i_ddr_addr`  in  27  start address in 16-byte beats, relative to the bank.
- `i_ddr_size`  in  32  transfer size in bytes; bits [3:0] ignored.
- `i_wr_data`  in  128  write data from the output data RAM.
- `o_wr_data_req`  out  1  write beat accepted; pops `i_wr_data`.
- `o_avm_address`  out  27  beat address.
- `o_avm_burstcount`  out  8  beats in the current burst.
- `o_avm_read`  out  1  read command.
- `o_avm_write`  out  1  write beat valid.
- `o_avm_writedata`  out  128  equals `i_wr_data`.
- `i_avm_waitrequest`  in  1  slave stall.
- `i_avm_readdatavalid`  in  1  read beat returned.
- `o_rd_valid`  out  1  registered copy of `i_avm_readdatavalid`, feeds the Rx FIFO write.
- `o_busy`  out  1  an order is in progress.
- `o_ddr_endp`  out  1  one-cycle order-complete pulse.
- `o_ddr_err`  out  1  qualifies `o_ddr_endp` as an aborted order.

## Operation
- **Start:** a rising edge of `i_ddr_start` in IDLE latches wxr, area, addr and size (beats = size[31:4]).
  - Edges while busy are ignored.
  - A fall of `i_ddr_start` mid-order is ignored; the order runs to completion.
- **Bank:** back = area when area is 1..3, else 0.
  - bank = frame_time − back; if negative, add frame_max+1.
  - Physical address = addr + bank*P_BANK_OFS, truncated to 27 bits.
  - Computed once, in CALC.
- **Burst length:** min(remaining, P_BURST_MAX − (cur_addr mod P_BURST_MAX)). No burst crosses a P_BURST_MAX boundary.
- **FSM:**
  - IDLE → CALC on start edge.
  - CALC → DONE when beats == 0.
  - CALC → RD_CMD when wxr = 0, or WR_BEAT when wxr = 1.
  - RD_CMD holds `o_avm_read` until `!i_avm_waitrequest`, then → RD_WAIT.
  - RD_WAIT counts `i_avm_readdatavalid`. At burst end: → RD_CMD if beats remain, else → DONE. Only one read burst is outstanding at a time.
  - WR_BEAT holds `o_avm_write`. Each cycle with `!i_avm_waitrequest` accepts one beat and pulses `o_wr_data_req`. Address and burstcount are constant across the burst. After the last beat of the last burst → DONE.
  - DONE pulses `o_ddr_endp` → IDLE.
- `o_busy` = 1 in every state except IDLE.
- Readdatavalid beats arriving in IDLE are counted nowhere but still forwarded on `o_rd_valid`.

## Timing
- Reset value of every output is 0. FSM resets to IDLE.
- `i_ddr_start` rises at cycle N:
  - CALC at N+1.
  - First `o_avm_read`/`o_avm_write` with valid address and burstcount at N+2.
- `o_ddr_endp` asserts 1 cycle after the last readdatavalid or the last accepted write beat.
- Zero-size order: `o_ddr_endp` at N+2.
- `o_rd_valid` lags `i_avm_readdatavalid` by 1 cycle.
- Back-to-back orders: a new start edge is accepted from the cycle after `o_ddr_endp`.
- Asserting reset mid-burst: outputs drop to 0 immediately. No `o_ddr_endp` is issued.

## Configuration
- `SP_IF_DDR_TIMEOUT_EN` defined:
  - A watchdog counts consecutive cycles in RD_CMD/WR_BEAT with waitrequest=1, or in RD_WAIT without readdatavalid.
  - At P_TMO_CYC the FSM goes to DONE. `o_ddr_endp` and `o_ddr_err` pulse together.
  - The counter clears on any progress.
- Undefined: no watchdog logic; `o_ddr_err` tied to 0.

## Test plan
- Read, area 0, frame_time 2, addr 0x10, size 0x400 (64 beats), P_BURST_MAX 64, no wait states → bursts of 48 at 0x10 then 16 at 0x40; `o_ddr_endp` 1 cycle after the 64th `o_rd_valid`-source beat.
- Write, area 3, frame_time 1, frame_max 3, addr 0 → bank 2, first address 0x0200000, burstcount min(beats, 64). Random waitrequest; `o_wr_data_req` count equals beats exactly.
- size 0x0 and size 0xF → `o_ddr_endp` at N+2, no read/write asserted.
- Second start edge while busy, and `i_ddr_start` dropped mid-order → ignored; exactly one `o_ddr_endp`.
- Reset asserted mid-write burst, then a new order → all outputs 0 during reset; new order completes normally.
- With `SP_IF_DDR_TIMEOUT_EN`, P_TMO_CYC 100, waitrequest stuck at 1 → `o_ddr_endp` and `o_ddr_err` together after 100 stall cycles; without the macro the block stays busy.
